// File: rtl/fft_pkg.sv
// Shared types and constants for the CBFP scale-index tracking path.
package fft_pkg;

    localparam int IDX_W = 5;
    localparam int BEATS = 32;

    typedef struct packed {
        logic             sof;
        logic             eof;
        logic [IDX_W-1:0] h;
        logic [IDX_W-1:0] l;
    } cbfp_idx_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with an occupancy count and sticky error flags.
module sync_fifo_fwft #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_rd   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a write at full is still accepted.
    assign do_wr   = wr_en && (!full || rd_en);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (wr_en && full && !rd_en) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fft_cbfp_index_fifo.sv
// Tags CBFP scale indices with frame position, buffers them for the downstream consumer,
// and tracks the minimum index of each completed frame.
module fft_cbfp_index_fifo #(
    parameter int IDX_W = fft_pkg::IDX_W,
    parameter int DEPTH = 64,
    parameter int BEATS = fft_pkg::BEATS
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   valid_in,
    input  logic [IDX_W-1:0]       index_h_in,
    input  logic [IDX_W-1:0]       index_l_in,
    input  logic                   rd_en,
    output logic                   idx_valid,
    output logic [IDX_W-1:0]       index_h_out,
    output logic [IDX_W-1:0]       index_l_out,
    output logic                   sof_out,
    output logic                   eof_out,
    output logic [IDX_W-1:0]       frame_min_h,
    output logic [IDX_W-1:0]       frame_min_l,
    output logic                   frame_done,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   underflow
);

    import fft_pkg::*;

    localparam int BW = $clog2(BEATS);

    logic [BW-1:0]    beat_cnt;
    logic             is_sof;
    logic             is_eof;
    cbfp_idx_t        wr_entry;
    cbfp_idx_t        head;
    logic [IDX_W-1:0] run_min_h;
    logic [IDX_W-1:0] run_min_l;
    logic [IDX_W-1:0] next_min_h;
    logic [IDX_W-1:0] next_min_l;

    function automatic logic [IDX_W-1:0] umin(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    assign is_sof     = (beat_cnt == '0);
    assign is_eof     = (beat_cnt == BW'(BEATS - 1));
    assign next_min_h = umin(run_min_h, index_h_in);
    assign next_min_l = umin(run_min_l, index_l_in);

    always_comb begin
        wr_entry     = '0;
        wr_entry.sof = is_sof;
        wr_entry.eof = is_eof;
        wr_entry.h   = index_h_in;
        wr_entry.l   = index_l_in;
    end

    // Beat counter runs on every strobe, dropped or not, so framing follows the data stream.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_cnt <= '0;
        end else if (valid_in) begin
            beat_cnt <= is_eof ? '0 : beat_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            run_min_h   <= '1;
            run_min_l   <= '1;
            frame_min_h <= '0;
            frame_min_l <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= valid_in && is_eof;
            if (valid_in) begin
                if (is_eof) begin
                    frame_min_h <= next_min_h;
                    frame_min_l <= next_min_l;
                    run_min_h   <= '1;
                    run_min_l   <= '1;
                end else begin
                    run_min_h   <= next_min_h;
                    run_min_l   <= next_min_l;
                end
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH ($bits(cbfp_idx_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (valid_in),
        .wr_data   (wr_entry),
        .rd_en     (rd_en),
        .rd_data   (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Head fields are forced to zero when nothing is stored so stale storage never leaks out.
    assign idx_valid   = !fifo_empty;
    assign index_h_out = idx_valid ? head.h   : '0;
    assign index_l_out = idx_valid ? head.l   : '0;
    assign sof_out     = idx_valid ? head.sof : 1'b0;
    assign eof_out     = idx_valid ? head.eof : 1'b0;

endmodule
